spi_sclk_gen: RTL and testbench
===============================

SPI_SCLK_GEN -- requirements
Module: spi_sclk_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 8, divider width; half period = divider+1 clk_in cycles.
REQ-002 SHALL have parameter CNT_W, default 7, width of the bit-count input.
REQ-003 SHALL have clk_in  input  1  system clock; the single clock.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have start  input  1  one-cycle transfer request.
REQ-006 SHALL have divider  input  DIV_W  half-period divider.
REQ-007 SHALL have nbits  input  CNT_W  bits per transfer.
REQ-008 SHALL have cpol, cpha  input  1 each  SPI mode.
REQ-009 SHALL have sclk  output  1  serial clock.
REQ-010 SHALL have pos_edge, neg_edge  output  1 each  strobe, high in the first cycle sclk shows its new level.
REQ-011 SHALL have sample, shift  output  1 each  mode-mapped edge strobes.
REQ-012 SHALL have busy, done  output  1 each  transfer active; one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-014 IDLE: start=1 and nbits!=0 SHALL move to RUN and capture divider, nbits, cpol and cpha; start with nbits=0 SHALL be ignored.
REQ-015 Captured values SHALL remain stable for the whole transfer; input changes during RUN SHALL have no effect.
REQ-016 start in RUN SHALL be ignored; start in DONE (busy=0) SHALL be accepted.
REQ-017 The half-period counter SHALL load the divider on entry to RUN and decrement each cycle.
REQ-018 At counter zero, the half-period counter SHALL toggle sclk and reload the divider; all DIV_W-bit values are legal, and 0 means toggle every cycle.
REQ-019 Timing for start sampled in cycle T, captured divider D and nbits N:
  - busy=1 from T+1.
  - First sclk transition visible at T+D+2.
  - Subsequent transitions every D+1 cycles; exactly 2N transitions in total.
REQ-020 After the 2Nth transition, done=1 for exactly one cycle (T+2N(D+1)+2), with busy=0 in that cycle; the FSM then returns to IDLE.
REQ-021 Leading edge = transition away from cpol; trailing edge = transition back to cpol.
REQ-022 cpha=0: sample SHALL pulse on leading edges and shift on trailing edges.
REQ-023 cpha=1: shift SHALL pulse on leading edges and sample on trailing edges.
REQ-024 pos_edge/neg_edge SHALL reflect the physical sclk direction, independent of cpol.
REQ-025 In IDLE and DONE, sclk SHALL equal the live cpol input and all edge strobes SHALL be 0.
REQ-026 The edge counter SHALL be CNT_W+1 bits so that 2N never wraps at N=2^CNT_W-1.

Reset
REQ-027 rst=1 at a clk_in edge SHALL force:
  - FSM to IDLE;
  - counters to 0;
  - sclk=cpol;
  - pos_edge, neg_edge, sample, shift, busy and done to 0.
REQ-028 rst mid-transfer SHALL abort the transfer with no done pulse; start SHALL be accepted on the first cycle after rst deasserts.

Structure
REQ-029 Package spi_pkg SHALL hold the FSM state encoding and the default DIV_W and CNT_W constants.
REQ-030 The half-period counter SHALL be sub-module spi_half_cnt (load, decrement, zero flag).
REQ-031 All outputs SHALL be registered.

Verification
REQ-032 D=0, N=1, cpol=0, cpha=0, start@0 -> busy@1; sclk=1 with pos_edge and sample @2; sclk=0 with neg_edge and shift @3; done@4.
REQ-033 D=3, N=8, cpol=1, cpha=1 -> sclk idles 1; 16 transitions @5,9,...,65; neg_edge with shift on leading edges; pos_edge with sample on trailing edges; done@66.
REQ-034 D=255, N=1 -> transitions 256 cycles apart (@257, @513); done@514.
REQ-035 start repeated during RUN, and divider/cpol changed mid-transfer -> no restart and timing unchanged; start in the done cycle -> new transfer with busy the next cycle.
REQ-036 nbits=0 with start -> busy stays 0 and no done pulse.
REQ-037 rst asserted at cycle 20 of a D=3, N=8 transfer -> all outputs at reset values next cycle; no done pulse; fresh transfer then completes normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI serial-clock generator.
package spi_pkg;

    localparam int unsigned SPI_DIV_W_DEF = 8;
    localparam int unsigned SPI_CNT_W_DEF = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_half_cnt.sv
// Half-period down-counter: loads a reload value, decrements while enabled,
// reloads on reaching zero and flags the zero count.
module spi_half_cnt
    import spi_pkg::*;
#(
    parameter int unsigned DIV_W = SPI_DIV_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [DIV_W-1:0] cnt;

    // Load has priority; while enabled count down and wrap back to the reload value.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            if (cnt == '0) begin
                cnt <= load_val;
            end else begin
                cnt <= cnt - DIV_W'(1);
            end
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: produces sclk and mode-mapped edge strobes for
// a transfer of nbits bits with a programmable half period.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int unsigned DIV_W = SPI_DIV_W_DEF,
    parameter int unsigned CNT_W = SPI_CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] divider,
    input  logic [CNT_W-1:0] nbits,
    input  logic             cpol,
    input  logic             cpha,
    output logic             sclk,
    output logic             pos_edge,
    output logic             neg_edge,
    output logic             sample,
    output logic             shift,
    output logic             busy,
    output logic             done
);

    spi_state_t       state, state_nxt;
    logic [DIV_W-1:0] div_r;
    logic [CNT_W-1:0] nbits_r;
    logic             cpol_r, cpha_r;
    logic [CNT_W:0]   edge_cnt;
    logic             half_zero;
    logic             accept, all_edges, toggle, leading;
    logic             sclk_nxt, pos_nxt, neg_nxt, sample_nxt, shift_nxt;
    logic             busy_nxt, done_nxt;

    assign accept    = start && (nbits != '0) && (state != ST_RUN);
    assign all_edges = (edge_cnt == {nbits_r, 1'b0});
    assign toggle    = (state == ST_RUN) && half_zero && !all_edges;
    assign leading   = (sclk == cpol_r);

    spi_half_cnt #(
        .DIV_W (DIV_W)
    ) u_half_cnt (
        .clk_in   (clk_in),
        .rst      (rst),
        .load     (accept),
        .load_val (accept ? divider : div_r),
        .en       (state == ST_RUN),
        .zero     (half_zero)
    );

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_nxt  = state;
        sclk_nxt   = cpol;
        pos_nxt    = 1'b0;
        neg_nxt    = 1'b0;
        sample_nxt = 1'b0;
        shift_nxt  = 1'b0;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_nxt = ST_RUN;
                    busy_nxt  = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (all_edges) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                end else begin
                    busy_nxt = 1'b1;
                    sclk_nxt = sclk;
                    if (toggle) begin
                        sclk_nxt   = ~sclk;
                        pos_nxt    = ~sclk;
                        neg_nxt    = sclk;
                        sample_nxt = leading ^ cpha_r;
                        shift_nxt  = ~(leading ^ cpha_r);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sclk     <= cpol;
            pos_edge <= 1'b0;
            neg_edge <= 1'b0;
            sample   <= 1'b0;
            shift    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            sclk     <= sclk_nxt;
            pos_edge <= pos_nxt;
            neg_edge <= neg_nxt;
            sample   <= sample_nxt;
            shift    <= shift_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    // Transfer parameters captured at acceptance; edge count steps per toggle.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            div_r    <= '0;
            nbits_r  <= '0;
            cpol_r   <= 1'b0;
            cpha_r   <= 1'b0;
            edge_cnt <= '0;
        end else if (accept) begin
            div_r    <= divider;
            nbits_r  <= nbits;
            cpol_r   <= cpol;
            cpha_r   <= cpha;
            edge_cnt <= '0;
        end else if (toggle) begin
            edge_cnt <= edge_cnt + (CNT_W+1)'(1);
        end
    end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Directed self-checking bench for spi_sclk_gen.
module tb_spi_sclk_gen;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] divider;
    logic [6:0] nbits;
    logic       cpol, cpha;
    logic       sclk, pos_edge, neg_edge, sample, shift, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    spi_sclk_gen #(
        .DIV_W (8),
        .CNT_W (7)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .start    (start),
        .divider  (divider),
        .nbits    (nbits),
        .cpol     (cpol),
        .cpha     (cpha),
        .sclk     (sclk),
        .pos_edge (pos_edge),
        .neg_edge (neg_edge),
        .sample   (sample),
        .shift    (shift),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit e_sclk, input bit e_pos, input bit e_neg,
                           input bit e_smp, input bit e_shf, input bit e_busy, input bit e_done);
        chk({tag, " sclk"},   32'(sclk),     32'(e_sclk));
        chk({tag, " pos"},    32'(pos_edge), 32'(e_pos));
        chk({tag, " neg"},    32'(neg_edge), 32'(e_neg));
        chk({tag, " sample"}, 32'(sample),   32'(e_smp));
        chk({tag, " shift"},  32'(shift),    32'(e_shf));
        chk({tag, " busy"},   32'(busy),     32'(e_busy));
        chk({tag, " done"},   32'(done),     32'(e_done));
    endtask

    // Entered in cycle 1 (start sampled at the end of cycle 0); returns in the
    // done cycle, or right after a reset when abort_at is nonzero.
    task automatic watch(input string tag, input int d, input int n, input bit pol,
                         input bit pha, input bit disturb, input int abort_at);
        int  last;
        int  kk;
        bit  tr, lead, lvl;
        last = 2 * n * (d + 1) + 2;
        for (int c = 1; c <= last; c++) begin
            tr = 1'b0;
            kk = 0;
            if (c >= d + 2) begin
                kk = (c - (d + 2)) / (d + 1) + 1;
                tr = (((c - (d + 2)) % (d + 1)) == 0) && (kk <= 2 * n);
                if (kk > 2 * n) kk = 2 * n;
            end
            lvl  = pol ^ kk[0];
            lead = kk[0];
            chk_all($sformatf("%s c%0d", tag, c), lvl, tr && lvl, tr && !lvl,
                    tr && (lead != pha), tr && (lead == pha), c < last, c == last);
            if (disturb && c == 3) begin
                start   = 1'b1;
                divider = 8'd0;
                cpol    = ~pol;
                cpha    = ~pha;
                nbits   = 7'd1;
            end
            if (disturb && c == 11) begin
                start   = 1'b0;
                divider = 8'(d);
                cpol    = pol;
                cpha    = pha;
                nbits   = 7'(n);
            end
            if (abort_at != 0 && c == abort_at) begin
                rst = 1'b1;
                tick();
                chk_all({tag, " after rst"}, pol, 0, 0, 0, 0, 0, 0);
                rst = 1'b0;
                return;
            end
            if (c < last) tick();
        end
    endtask

    task automatic launch(input int d, input int n, input bit pol, input bit pha);
        divider = 8'(d);
        nbits   = 7'(n);
        cpol    = pol;
        cpha    = pha;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; divider = '0; nbits = '0; cpol = 1'b0; cpha = 1'b0;
        tick();
        tick();
        chk_all("reset cpol0", 0, 0, 0, 0, 0, 0, 0);
        cpol = 1'b1;
        tick();
        chk_all("reset cpol1", 1, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        cpol = 1'b0;
        tick();
        chk_all("idle", 0, 0, 0, 0, 0, 0, 0);

        // D=0, N=1, mode 0
        launch(0, 1, 0, 0);
        watch("m0", 0, 1, 0, 0, 0, 0);
        tick();

        // D=3, N=8, mode 3
        launch(3, 8, 1, 1);
        watch("m3", 3, 8, 1, 1, 0, 0);
        tick();

        // D=255, N=1, then a new transfer started in the done cycle
        launch(255, 1, 0, 0);
        watch("d255", 255, 1, 0, 0, 0, 0);
        launch(1, 2, 0, 1);
        watch("chain", 1, 2, 0, 1, 0, 0);
        tick();

        // start, divider, cpol, cpha and nbits disturbed mid-transfer
        launch(3, 2, 0, 0);
        watch("disturb", 3, 2, 0, 0, 1, 0);
        tick();

        // nbits=0 is ignored
        launch(5, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("nbits0 busy %0d", i), 32'(busy), 32'd0);
            chk($sformatf("nbits0 done %0d", i), 32'(done), 32'd0);
            tick();
        end

        // reset at cycle 20 of a D=3, N=8 transfer, then an immediate restart
        launch(3, 8, 0, 0);
        watch("abort", 3, 8, 0, 0, 0, 20);
        launch(3, 8, 0, 0);
        watch("post", 3, 8, 0, 0, 0, 0);
        tick();
        chk_all("final idle", 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
